// File: rtl/in_cond4_frame_config.sv
// ---------------------------------------------------------------------------------------------
// in_cond4_frame_config
//
// Four-channel input conditioner for the RAM_IO tile. It sits directly upstream of the
// four-bit input-pass BEL. Each raw pad input goes through three stages:
//   - a 2-flop synchronizer;
//   - a glitch filter with a shared, configurable threshold;
//   - a per-channel output-mode selector: level, rising pulse, falling pulse or toggle.
// Behaviour is fixed entirely by the frame configuration bits. There is no runtime handshake.
//
// Parameters
//   NoConfigBits : width of ConfigBits (8 mode bits + TH_W threshold bits)
//   TH_W         : width of the filter threshold and the per-channel mismatch counter
//
// Ports
//   UserCLK    : fabric user clock, the only clock
//   Reset      : synchronous, active-high reset
//   PAD_I      : raw pad inputs, asynchronous to UserCLK
//   O          : conditioned outputs, feeding the input-pass BEL I[3:0]
//   ConfigBits : [2k+1:2k] mode of channel k (00 level, 01 rise, 10 fall, 11 toggle);
//                [8 +: TH_W] shared filter threshold TH
// ---------------------------------------------------------------------------------------------
module in_cond4_frame_config #(
    parameter int unsigned NoConfigBits = 12,
    parameter int unsigned TH_W         = 4
) (
    input  logic                    UserCLK,
    input  logic                    Reset,
    input  logic [3:0]              PAD_I,
    output logic [3:0]              O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam logic [1:0] ModeLevel  = 2'b00;
    localparam logic [1:0] ModeRise   = 2'b01;
    localparam logic [1:0] ModeFall   = 2'b10;
    localparam logic [1:0] ModeToggle = 2'b11;

    // Shared filter threshold
    logic [TH_W-1:0] th;
    assign th = ConfigBits[8 +: TH_W];

    // Synchronizer stages. s1 is the only flop that samples an asynchronous signal.
    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;

    // Filter state: the filtered level and the consecutive-mismatch counter
    logic [3:0]           f_q, f_d;
    logic [3:0][TH_W-1:0] cnt_q, cnt_d;

    // One-cycle-delayed filtered level used for edge detection, plus the toggle register
    logic [3:0] fd_q, fd_d;
    logic [3:0] t_q, t_d;

    logic [3:0] rise;
    logic [3:0] fall;

    always_comb begin
        rise = f_q & ~fd_q;
        fall = ~f_q & fd_q;
    end

    // Next-state logic
    always_comb begin
        s1_d  = PAD_I;
        s2_d  = s1_q;
        fd_d  = f_q;
        // T tracks rising edges in every mode, so switching into toggle mode shows the
        // accumulated parity rather than a freshly cleared value.
        t_d   = t_q ^ rise;
        f_d   = f_q;
        cnt_d = '0;
        for (int k = 0; k < 4; k++) begin
            if (s2_q[k] != f_q[k]) begin
                // The >= compare lets a lowered TH take effect at once, even when the
                // running count is already above the new threshold.
                if (cnt_q[k] >= th) begin
                    f_d[k] = s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + TH_W'(1);
                end
            end
            // A matching cycle leaves cnt_d at zero, so a broken mismatch run restarts.
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            f_q   <= '0;
            cnt_q <= '0;
            fd_q  <= '0;
            t_q   <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            f_q   <= f_d;
            cnt_q <= cnt_d;
            fd_q  <= fd_d;
            t_q   <= t_d;
        end
    end

    // Output selection is combinational from registered state, so a mode change shows
    // up in the same cycle without disturbing any channel state.
    always_comb begin
        O = '0;
        for (int k = 0; k < 4; k++) begin
            case (ConfigBits[2*k +: 2])
                ModeLevel:  O[k] = f_q[k];
                ModeRise:   O[k] = rise[k];
                ModeFall:   O[k] = fall[k];
                ModeToggle: O[k] = t_q[k];
                default:    O[k] = 1'b0;
            endcase
        end
    end

endmodule
